// File: rtl/bound_flasher_monitor.sv
// Passive decoder/checker for the bound-flasher LED bus: tracks the sweep phase and direction,
// pulses on kickbacks and completed sweeps, and flags protocol violations.
module bound_flasher_monitor #(
  parameter int LED_W   = 16,
  parameter int BOUND_A = 6,
  parameter int BOUND_B = 11,
  parameter int BOUND_C = 5,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LED_W-1:0] LED,
  input  logic             flick,
  output logic [2:0]       phase,
  output logic             dir_up,
  output logic             active,
  output logic [4:0]       lit,
  output logic             kick,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count,
  output logic             err,
  output logic [2:0]       err_code
);

  typedef enum logic [1:0] {IDLE, UP, DOWN, RESYNC} state_t;

  localparam logic [2:0] E_ILLEGAL   = 3'd1;
  localparam logic [2:0] E_NO_FLICK  = 3'd2;
  localparam logic [2:0] E_BAD_STEP  = 3'd3;
  localparam logic [2:0] E_TURN      = 3'd4;
  localparam logic [2:0] E_FLICK_IGN = 3'd5;

  function automatic logic [4:0] lit_cnt(input logic [LED_W-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < LED_W; i++) c = c + 5'(v[i]);
    return c;
  endfunction

  // A thermometer code plus one has no bits in common with itself.
  function automatic logic therm_ok(input logic [LED_W-1:0] v);
    return (v & (v + LED_W'(1))) == '0;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [4:0] up_tgt(input logic [2:0] k);
    case (k)
      3'd0:    return 5'(BOUND_A);
      3'd2:    return 5'(BOUND_B);
      default: return 5'(LED_W);
    endcase
  endfunction

  function automatic logic [4:0] dn_tgt(input logic [2:0] k);
    return (k == 3'd3) ? 5'(BOUND_C) : 5'd0;
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic [LED_W-1:0] led_p1;
  logic             flick_p1;
  logic [4:0]       lit_q;
  logic             kick_q, kick_d;
  logic             done_q, done_d;
  logic             err_q;
  logic [2:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [4:0] p_lit, n_lit;
  logic       legal, kick_pt, fault;
  logic [2:0] fault_code;

  assign p_lit   = lit_cnt(led_p1);
  assign n_lit   = lit_cnt(LED);
  assign legal   = therm_ok(LED);
  assign kick_pt = ((phase_q == 3'd2) || (phase_q == 3'd4)) &&
                   ((p_lit == 5'(BOUND_A)) || (p_lit == 5'(BOUND_B))) && flick_p1;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    kick_d     = 1'b0;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    fault      = 1'b0;
    fault_code = '0;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        if (!legal) begin
          fault = 1'b1; fault_code = E_ILLEGAL;
        end else if (n_lit == 5'd0) begin
          state_d = IDLE;
        end else if (n_lit == 5'd1) begin
          if (flick_p1) state_d = UP;
          else begin fault = 1'b1; fault_code = E_NO_FLICK; end
        end else begin
          fault = 1'b1; fault_code = E_BAD_STEP;
        end
      end
      UP: begin
        if (!legal) begin
          fault = 1'b1; fault_code = E_ILLEGAL;
        end else if (n_lit == p_lit + 5'd1) begin
          if (kick_pt) begin fault = 1'b1; fault_code = E_FLICK_IGN; end
          else if (p_lit >= up_tgt(phase_q)) begin fault = 1'b1; fault_code = E_BAD_STEP; end
        end else if ((p_lit != 5'd0) && (n_lit == p_lit - 5'd1)) begin
          // A kickback wins over the normal turn at the same LED count.
          if (kick_pt) begin
            state_d = DOWN; phase_d = phase_q - 3'd1; kick_d = 1'b1;
          end else if (p_lit == up_tgt(phase_q)) begin
            state_d = DOWN; phase_d = phase_q + 3'd1;
          end else begin
            fault = 1'b1; fault_code = E_TURN;
          end
        end else begin
          fault = 1'b1; fault_code = E_BAD_STEP;
        end
      end
      DOWN: begin
        if (!legal) begin
          fault = 1'b1; fault_code = E_ILLEGAL;
        end else if ((p_lit != 5'd0) && (n_lit == p_lit - 5'd1) && (p_lit > dn_tgt(phase_q))) begin
          state_d = DOWN;
        end else if (((phase_q == 3'd1) || (phase_q == 3'd3)) &&
                     (p_lit == dn_tgt(phase_q)) && (n_lit == p_lit + 5'd1)) begin
          state_d = UP; phase_d = phase_q + 3'd1;
        end else if ((phase_q == 3'd5) && (p_lit == 5'd0) && (n_lit == 5'd0)) begin
          state_d = IDLE; phase_d = '0; done_d = 1'b1; cnt_d = sat_inc(cnt_q);
        end else begin
          fault = 1'b1; fault_code = E_BAD_STEP;
        end
      end
      default: begin
        phase_d = '0;
        if ((p_lit == 5'd0) && (n_lit == 5'd0)) state_d = IDLE;
      end
    endcase
    err_code_d = err_code_q;
    if (fault) begin
      state_d    = RESYNC;
      phase_d    = '0;
      kick_d     = 1'b0;
      done_d     = 1'b0;
      cnt_d      = cnt_q;
      err_code_d = fault_code;
    end
  end

  // p1: sampled bus and registered decode results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      led_p1     <= '0;
      flick_p1   <= 1'b0;
      lit_q      <= '0;
      kick_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      led_p1     <= LED;
      flick_p1   <= flick;
      lit_q      <= n_lit;
      kick_q     <= kick_d;
      done_q     <= done_d;
      err_q      <= fault;
      err_code_q <= err_code_d;
      cnt_q      <= cnt_d;
    end
  end

  assign active      = (state_q == UP) || (state_q == DOWN);
  assign dir_up      = (state_q == UP);
  assign phase       = active ? phase_q : 3'd0;
  assign lit         = lit_q;
  assign kick        = kick_q;
  assign done        = done_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_bound_flasher_monitor.sv
// Directed bench for bound_flasher_monitor: sweeps, kickbacks, error codes, saturation, reset.
module tb_bound_flasher_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] LED = '0;
  logic        flick = 1'b0;
  logic [2:0]  phase;
  logic        dir_up, active, kick, done, err;
  logic [4:0]  lit;
  logic [7:0]  cycle_count;
  logic [2:0]  err_code;

  int checks = 0;
  int errors = 0;

  bound_flasher_monitor dut (
    .clk(clk), .rst_n(rst_n), .LED(LED), .flick(flick),
    .phase(phase), .dir_up(dir_up), .active(active), .lit(lit),
    .kick(kick), .done(done), .cycle_count(cycle_count),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] th(input int n);
    return 16'((32'd1 << n) - 1);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input logic [15:0] l, input logic f);
    LED = l;
    flick = f;
    @(posedge clk);
    #1;
  endtask

  task automatic ramp(input int from, input int to, input int ph, input bit c);
    int step;
    step = (to >= from) ? 1 : -1;
    for (int v = from; v != to + step; v += step) begin
      tick(th(v), 1'b0);
      if (c) begin
        chk("ramp_phase", phase, ph);
        chk("ramp_err", err, 0);
        chk("ramp_done", done, 0);
      end
    end
  endtask

  task automatic sweep(input bit c);
    tick(16'h0000, 1'b1);
    ramp(1, 6, 0, c);
    ramp(5, 0, 1, c);
    ramp(1, 11, 2, c);
    ramp(10, 5, 3, c);
    ramp(6, 16, 4, c);
    ramp(15, 0, 5, c);
    tick(16'h0000, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_phase"}, phase, 0);
    chk({tag, "_dir_up"}, dir_up, 0);
    chk({tag, "_active"}, active, 0);
    chk({tag, "_lit"}, lit, 0);
    chk({tag, "_kick"}, kick, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_count"}, cycle_count, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_code"}, err_code, 0);
  endtask

  initial begin
    // reset state
    rst_n = 1'b0;
    tick(16'h00FF, 1'b1);
    tick(16'h00FF, 1'b1);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(16'h0000, 1'b0);
    tick(16'h0000, 1'b0);

    // clean full sweep
    sweep(1'b1);
    chk("sweep1_done", done, 1);
    chk("sweep1_phase", phase, 0);
    chk("sweep1_active", active, 0);
    chk("sweep1_count", cycle_count, 1);
    chk("sweep1_code", err_code, 0);
    tick(16'h0000, 1'b0);
    chk("sweep1_done_pulse", done, 0);

    // kickback in phase 2, then in phase 4, within one sweep
    tick(16'h0000, 1'b1);
    ramp(1, 6, 0, 1'b1);
    ramp(5, 0, 1, 1'b1);
    ramp(1, 5, 2, 1'b1);
    tick(16'h003F, 1'b1);
    chk("k2_pre_phase", phase, 2);
    chk("k2_pre_lit", lit, 6);
    chk("k2_pre_dir", dir_up, 1);
    tick(16'h001F, 1'b0);
    chk("k2_kick", kick, 1);
    chk("k2_phase", phase, 1);
    chk("k2_dir", dir_up, 0);
    chk("k2_err", err, 0);
    tick(16'h000F, 1'b0);
    chk("k2_kick_pulse", kick, 0);
    chk("k2_phase_hold", phase, 1);
    ramp(3, 0, 1, 1'b1);
    ramp(1, 11, 2, 1'b1);
    ramp(10, 5, 3, 1'b1);
    ramp(6, 10, 4, 1'b1);
    tick(16'h07FF, 1'b1);
    chk("k4_pre_phase", phase, 4);
    tick(16'h03FF, 1'b0);
    chk("k4_kick", kick, 1);
    chk("k4_phase", phase, 3);
    chk("k4_err", err, 0);
    ramp(9, 5, 3, 1'b1);
    tick(16'h003F, 1'b0);
    chk("k4_reup_phase", phase, 4);
    chk("k4_reup_dir", dir_up, 1);
    ramp(7, 16, 4, 1'b1);
    chk("full_lit", lit, 16);
    ramp(15, 0, 5, 1'b1);
    tick(16'h0000, 1'b0);
    chk("sweep2_done", done, 1);
    chk("sweep2_count", cycle_count, 2);

    // illegal code, resync, restart; then unexpected turn
    tick(16'h0000, 1'b1);
    ramp(1, 3, 0, 1'b1);
    tick(16'h0005, 1'b0);
    chk("illegal_err", err, 1);
    chk("illegal_code", err_code, 1);
    chk("illegal_active", active, 0);
    tick(16'h0000, 1'b0);
    chk("resync_err", err, 0);
    chk("resync_code_hold", err_code, 1);
    tick(16'h0000, 1'b0);
    tick(16'h0000, 1'b1);
    tick(16'h0001, 1'b0);
    chk("restart_active", active, 1);
    chk("restart_phase", phase, 0);
    tick(16'h0000, 1'b0);
    chk("turn_err", err, 1);
    chk("turn_code", err_code, 4);
    tick(16'h0000, 1'b0);

    // start without flick
    tick(16'h0000, 1'b0);
    tick(16'h0001, 1'b0);
    chk("noflick_err", err, 1);
    chk("noflick_code", err_code, 2);
    chk("noflick_active", active, 0);
    tick(16'h0000, 1'b0);
    tick(16'h0000, 1'b0);

    // flick ignored at a kick point
    tick(16'h0000, 1'b1);
    ramp(1, 6, 0, 1'b0);
    ramp(5, 0, 1, 1'b0);
    ramp(1, 5, 2, 1'b0);
    tick(16'h003F, 1'b1);
    tick(16'h007F, 1'b0);
    chk("flickign_err", err, 1);
    chk("flickign_code", err_code, 5);
    chk("flickign_kick", kick, 0);
    tick(16'h0000, 1'b0);
    tick(16'h0000, 1'b0);

    // flasher reset mid-sweep, then overshoot past the phase0 target
    tick(16'h0000, 1'b1);
    ramp(1, 4, 0, 1'b0);
    tick(16'h0000, 1'b0);
    chk("drop_code", err_code, 3);
    chk("drop_err", err, 1);
    tick(16'h0000, 1'b0);
    tick(16'h0000, 1'b1);
    ramp(1, 6, 0, 1'b0);
    tick(16'h0000, 1'b0);
    chk("overshoot_pre_code", err_code, 3);
    tick(16'h0000, 1'b0);
    tick(16'h0000, 1'b1);
    ramp(1, 6, 0, 1'b0);
    tick(16'h00FF, 1'b0);
    chk("overshoot_err", err, 1);
    chk("overshoot_code", err_code, 3);
    tick(16'h0000, 1'b0);
    tick(16'h0000, 1'b0);
    chk("count_after_errors", cycle_count, 2);

    // saturation of the sweep counter
    for (int s = 3; s <= 255; s++) sweep(1'b0);
    chk("sat_255", cycle_count, 255);
    sweep(1'b0);
    chk("sat_done", done, 1);
    chk("sat_hold", cycle_count, 255);

    // monitor reset mid-sweep
    tick(16'h0000, 1'b1);
    ramp(1, 8, 0, 1'b0);
    rst_n = 1'b0;
    tick(16'h01FF, 1'b0);
    check_all_zero("midreset");
    rst_n = 1'b1;
    tick(16'h03FF, 1'b0);
    chk("midreset_err", err, 1);
    chk("midreset_code", err_code, 3);
    tick(16'h07FF, 1'b0);
    tick(16'h0000, 1'b0);
    tick(16'h0000, 1'b0);
    sweep(1'b1);
    chk("post_reset_count", cycle_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
